field_line_clear: RTL and testbench
===================================

Name: field_line_clear

Overview:
Takes the latched playfield snapshot and removes every completely filled row. Rows above each removed row collapse downward, and the block reports how many lines were cleared. It sits between the playfield latch and the game controller. The controller pulses start after a piece locks, waits for done, then writes field_out back as the new background and uses lines_cleared for scoring.

Parameters:
ROWS, 20, number of playfield rows; row 0 is the top row.
COLS, 20, number of cells per row.
FIELD_W, ROWS*COLS (400), flattened field width.
CNT_W, 5, width of lines_cleared; must be at least clog2(ROWS+1).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset_n  input  1  asynchronous, active-low reset.
start  input  1  request pulse; sampled only in IDLE.
field_in  input  FIELD_W  playfield snapshot; row r = field_in[r*COLS +: COLS]; 1 = occupied.
busy  output  1  high from the cycle after start is accepted until done falls.
done  output  1  one-cycle pulse; field_out and lines_cleared are valid from this cycle on.
field_out  output  FIELD_W  compacted field; same row mapping as field_in.
lines_cleared  output  CNT_W  full rows removed in the last run (0..ROWS).
lines_total  output  16  saturating running total of cleared lines since reset.

Behaviour:
- Reset (async assert, sync-released state): state=IDLE; busy=0, done=0, field_out=0, lines_cleared=0, lines_total=0; internal working field and row index cleared.
- Reset asserted mid-run aborts immediately. No done pulse is produced and no partial result reaches field_out.
- States: IDLE, SCAN, SHIFT, DONE.
- IDLE: on an edge with start=1, load work<=field_in, row<=ROWS-1, run count<=0, go to SCAN. start=0 keeps IDLE. Outputs hold the last result.
- SCAN (one row per cycle): work row `row` all-ones -> SHIFT. Otherwise, row==0 -> DONE; else row<=row-1.
- SHIFT (one cycle):
  - work rows 1..row take old rows 0..row-1.
  - row 0 becomes all zeros.
  - rows row+1..ROWS-1 are unchanged.
  - count++.
  - Return to SCAN with the same row index, so the row that dropped in is re-checked.
- Entering DONE (same edge): field_out<=work, lines_cleared<=count, lines_total<=min(lines_total+count, 16'hFFFF).
- DONE: done=1 for exactly one cycle, then IDLE.
- busy=1 in SCAN, SHIFT and DONE.
- start while not in IDLE is ignored, with no queuing. A new start may be accepted on the first IDLE cycle after DONE.
- Latency with k full rows: done is high in the cycle following edge E0+ROWS+2k, where E0 is the accepting edge. Empty field gives 20 edges; all rows full (k=ROWS) gives 60 edges.
- Partially filled rows are never removed. Non-contiguous full rows are all removed, and relative order of surviving rows is preserved.
- Row index never wraps. Row 0 is the last row checked; a full row 0 is cleared via SHIFT (row 0 zeroed) and then re-checked as empty.

Decomposition:
- Package tetris_field_pkg holds:
  - ROWS, COLS, FIELD_W, CNT_W;
  - ROW_IDX_W = clog2(ROWS);
  - the state enum (IDLE/SCAN/SHIFT/DONE);
  - a row-slice helper function.
- One combinational sub-module, field_row_shift, takes (field, row index) and returns the collapsed field described under SHIFT.
- The FSM, counters and registers live in field_line_clear.

Test Plan:
- Empty field, start pulse -> done 20 edges after start; field_out=0; lines_cleared=0; busy high throughout.
- Bottom row (19) all ones, row 18 = 20'h00001 -> done after 22 edges; field_out row 19 = 20'h00001, rows 0..18 = 0; lines_cleared=1.
- Rows 19, 17 full; row 18 = 20'h00F00; row 16 = 20'h0000F -> lines_cleared=2; row 19 = 20'h00F00, row 18 = 20'h0000F, others 0; done after 24 edges.
- All 400 bits set -> lines_cleared=20; field_out=0; done after 60 edges.
- Start pulsed again at cycle 5 of a run with a different field_in -> ignored; result matches the first field only. lines_total accumulates across two runs (1 then 2 gives 3).
- reset_n low during SHIFT -> all outputs 0 immediately; no done pulse. After release, a fresh run with one full row gives lines_total=1.

Source files
------------

// File: rtl/tetris_field_pkg.sv
// Shared sizes, the line-clear FSM state type and a row-slice helper for the
// playfield line-clear logic.
package tetris_field_pkg;

  localparam int ROWS      = 20;
  localparam int COLS      = 20;
  localparam int FIELD_W   = ROWS * COLS;
  localparam int CNT_W     = 5;
  localparam int ROW_IDX_W = $clog2(ROWS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Row r occupies field[r*COLS +: COLS]; row 0 is the top of the playfield.
  function automatic logic [COLS-1:0] field_row(input logic [FIELD_W-1:0]   field,
                                                input logic [ROW_IDX_W-1:0] row);
    return field[int'(row)*COLS +: COLS];
  endfunction

endpackage

// File: rtl/field_row_shift.sv
// Combinational collapse of one removed row: rows 1..row take the row above,
// row 0 is emptied, rows below the removed row are untouched.
module field_row_shift
  import tetris_field_pkg::*;
(
  input  logic [FIELD_W-1:0]   field,
  input  logic [ROW_IDX_W-1:0] row,
  output logic [FIELD_W-1:0]   shifted
);

  always_comb begin
    shifted = field;
    shifted[COLS-1:0] = '0;
    for (int r = 1; r < ROWS; r++) begin
      if (r <= int'(row)) begin
        shifted[r*COLS +: COLS] = field[(r-1)*COLS +: COLS];
      end
    end
  end

endmodule

// File: rtl/field_line_clear.sv
// Scans the latched playfield bottom-up, removes every full row one at a time,
// and publishes the compacted field plus cleared-line counts when finished.
module field_line_clear
  import tetris_field_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [FIELD_W-1:0]  field_in,
  output logic                busy,
  output logic                done,
  output logic [FIELD_W-1:0]  field_out,
  output logic [CNT_W-1:0]    lines_cleared,
  output logic [15:0]         lines_total,
  output state_e              state_dbg
);

  // Handshake: start is a request taken only while idle (busy=0); done is a
  // one-cycle pulse after which field_out/lines_cleared hold until the next run.

  state_e                 state_q, state_d;
  logic [FIELD_W-1:0]     work_q, work_d;
  logic [ROW_IDX_W-1:0]   row_q, row_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [FIELD_W-1:0]     work_shifted;
  logic                   row_full;
  logic                   load_result;
  logic [16:0]            total_sum;
  logic [15:0]            total_sat;

  field_row_shift u_shift (
    .field   (work_q),
    .row     (row_q),
    .shifted (work_shifted)
  );

  assign row_full  = &field_row(work_q, row_q);
  assign total_sum = {1'b0, lines_total} + 17'(count_q);
  assign total_sat = total_sum[16] ? 16'hFFFF : total_sum[15:0];

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    row_d       = row_q;
    count_d     = count_q;
    load_result = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          work_d  = field_in;
          row_d   = ROW_IDX_W'(ROWS - 1);
          count_d = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (row_full) begin
          state_d = SHIFT;
        end else if (row_q == '0) begin
          state_d     = DONE;
          load_result = 1'b1;
        end else begin
          row_d = row_q - ROW_IDX_W'(1);
        end
      end
      SHIFT: begin
        // Same row index is kept so the row that dropped in gets re-checked.
        work_d  = work_shifted;
        count_d = count_q + CNT_W'(1);
        state_d = SCAN;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      work_q        <= '0;
      row_q         <= '0;
      count_q       <= '0;
      field_out     <= '0;
      lines_cleared <= '0;
      lines_total   <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      row_q   <= row_d;
      count_q <= count_d;
      if (load_result) begin
        field_out     <= work_q;
        lines_cleared <= count_q;
        lines_total   <= total_sat;
      end
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_field_line_clear.sv
// Bench for field_line_clear: directed and random playfields checked against a
// row-list reference model through an expected-result queue.
module tb_field_line_clear;
  import tetris_field_pkg::*;

  localparam int  W = FIELD_W + CNT_W + 16 + 8;
  localparam time P = 10;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               start = 1'b0;
  logic [FIELD_W-1:0] field_in = '0;
  logic               busy;
  logic               done;
  logic [FIELD_W-1:0] field_out;
  logic [CNT_W-1:0]   lines_cleared;
  logic [15:0]        lines_total;
  state_e             state_dbg;

  int         tests = 0;
  int         fails = 0;
  logic [W-1:0] exp_q[$];
  time        t0 = 0;
  int         model_total = 0;

  field_line_clear dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .field_in      (field_in),
    .busy          (busy),
    .done          (done),
    .field_out     (field_out),
    .lines_cleared (lines_cleared),
    .lines_total   (lines_total),
    .state_dbg     (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #(P/2) clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [FIELD_W-1:0] act,
                       input logic [FIELD_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Keep surviving (not-full) rows in bottom-to-top order, stack them at the
  // bottom, fill the top with empty rows.
  function automatic void model(input logic [FIELD_W-1:0] f,
                                output logic [FIELD_W-1:0] o, output int k);
    logic [COLS-1:0] keep[$];
    logic [COLS-1:0] rv;
    int dst;
    for (int r = ROWS - 1; r >= 0; r--) begin
      rv = f[r*COLS +: COLS];
      if (rv != {COLS{1'b1}}) keep.push_back(rv);
    end
    o = '0;
    dst = ROWS - 1;
    foreach (keep[i]) begin
      o[dst*COLS +: COLS] = keep[i];
      dst--;
    end
    k = ROWS - keep.size();
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [W-1:0]       e;
    logic [FIELD_W-1:0] e_field;
    logic [CNT_W-1:0]   e_lines;
    logic [15:0]        e_total;
    logic [7:0]         e_lat;
    int                 lat;
    if (reset_n && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", FIELD_W'(done), FIELD_W'(0));
      end else begin
        e       = exp_q.pop_front();
        e_field = e[W-1 -: FIELD_W];
        e_lines = e[W-FIELD_W-1 -: CNT_W];
        e_total = e[23:8];
        e_lat   = e[7:0];
        lat     = int'(($time - t0 - P/2) / P);
        check("field_out", field_out, e_field);
        check("lines_cleared", FIELD_W'(lines_cleared), FIELD_W'(e_lines));
        check("lines_total", FIELD_W'(lines_total), FIELD_W'(e_total));
        check("latency", FIELD_W'(lat), FIELD_W'(e_lat));
      end
    end
  end

  // ---------------- drivers ----------------
  // Called at a negedge while the DUT is idle; returns at the negedge of the
  // first idle cycle after done.
  task automatic run_field(input logic [FIELD_W-1:0] f, input bit glitch);
    logic [FIELD_W-1:0] o;
    int  k;
    bit  busy_ok;
    bit  seen;
    model(f, o, k);
    model_total = (model_total + k > 65535) ? 65535 : model_total + k;
    exp_q.push_back({o, CNT_W'(k), 16'(model_total), 8'(ROWS + 2 * k)});
    start    = 1'b1;
    field_in = f;
    @(posedge clk);
    t0 = $time;
    #1 start = 1'b0;
    busy_ok = 1'b1;
    seen    = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (glitch && c == 4) begin
        start    = 1'b1;
        field_in = ~f;
      end
      if (glitch && c == 5) start = 1'b0;
      if (!busy) busy_ok = 1'b0;
      if (done) seen = 1'b1;
    end
    check("busy_during_run", FIELD_W'(busy_ok), FIELD_W'(1));
    check("done_seen", FIELD_W'(seen), FIELD_W'(1));
    if (!seen && exp_q.size() != 0) void'(exp_q.pop_front());
    @(negedge clk);
    check("done_one_cycle", FIELD_W'(done), FIELD_W'(0));
    check("idle_after_done", FIELD_W'(busy), FIELD_W'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, FIELD_W'(busy), FIELD_W'(0));
    check({tag, "_done"}, FIELD_W'(done), FIELD_W'(0));
    check({tag, "_field_out"}, field_out, FIELD_W'(0));
    check({tag, "_lines_cleared"}, FIELD_W'(lines_cleared), FIELD_W'(0));
    check({tag, "_lines_total"}, FIELD_W'(lines_total), FIELD_W'(0));
  endtask

  function automatic logic [FIELD_W-1:0] put_row(input logic [FIELD_W-1:0] f,
                                                 input int r, input logic [COLS-1:0] v);
    logic [FIELD_W-1:0] g;
    g = f;
    g[r*COLS +: COLS] = v;
    return g;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [FIELD_W-1:0] f;
    logic [COLS-1:0]    full_row;
    full_row = {COLS{1'b1}};

    #1 check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Empty field.
    run_field('0, 1'b0);
    // Bottom row full, single cell above.
    f = put_row('0, 19, full_row);
    f = put_row(f, 18, 20'h00001);
    run_field(f, 1'b0);
    // Two non-contiguous full rows.
    f = put_row('0, 19, full_row);
    f = put_row(f, 17, full_row);
    f = put_row(f, 18, 20'h00F00);
    f = put_row(f, 16, 20'h0000F);
    run_field(f, 1'b0);
    // Every row full.
    run_field({FIELD_W{1'b1}}, 1'b0);
    // Start retriggered mid-run with another field must be ignored.
    f = put_row('0, 19, full_row);
    f = put_row(f, 5, 20'hABCDE);
    run_field(f, 1'b1);

    // Randomised fields, mixing full rows and random partial rows.
    for (int n = 0; n < 10; n++) begin
      f = '0;
      for (int r = 0; r < ROWS; r++) begin
        if ($urandom_range(0, 2) == 0) f = put_row(f, r, full_row);
        else f = put_row(f, r, COLS'($urandom));
      end
      run_field(f, 1'b0);
    end

    // Reset during SHIFT aborts the run without a done pulse.
    start    = 1'b1;
    field_in = put_row('0, 19, full_row);
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("abort");
    model_total = 0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (30) @(negedge clk);
    check("abort_no_done_pending", FIELD_W'(exp_q.size()), FIELD_W'(0));

    // Fresh run after the abort.
    f = put_row('0, 19, full_row);
    f = put_row(f, 10, 20'h12345);
    run_field(f, 1'b0);

    check("queue_drained", FIELD_W'(exp_q.size()), FIELD_W'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // ---------------- final report guard ----------------
  initial begin
    #(P * 20000);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
